rv_wb_arb: RTL and testbench

//  Writeback arbiter directly upstream of the GPR write port (wr_en/wr_addr/wr_data).

---
 rtl/rv_wb_arb.sv | 137 +++++++++++++
 tb/tb_rv_wb_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_arb.sv
// Writeback arbiter: merges in-order source A and FIFO-buffered source B onto one GPR write port.
// Latency: 1 cycle from grant to wr_en_o; a B result needs at least 2 cycles from push to write.
// Backpressure: a_ready_o is the combinational grant; b_ready_o depends only on registered FIFO fullness.
module rv_wb_arb #(
    parameter int XLEN       = 32,
    parameter int GPR_ADDR_W = 5,
    parameter int B_DEPTH    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [GPR_ADDR_W-1:0] a_addr_i,
    input  logic [XLEN-1:0]       a_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [GPR_ADDR_W-1:0] b_addr_i,
    input  logic [XLEN-1:0]       b_data_i,
    output logic                  wr_en_o,
    output logic [GPR_ADDR_W-1:0] wr_addr_o,
    output logic [XLEN-1:0]       wr_data_o,
    input  logic [GPR_ADDR_W-1:0] r1_addr_i,
    input  logic [GPR_ADDR_W-1:0] r2_addr_i,
    output logic                  r1_fwd_o,
    output logic                  r2_fwd_o,
    output logic                  hazard_o
);

    localparam int PTR_W = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
    localparam int CNT_W = $clog2(B_DEPTH + 1);
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(B_DEPTH);
    localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

    logic [GPR_ADDR_W-1:0] ent_addr [B_DEPTH];
    logic [XLEN-1:0]       ent_data [B_DEPTH];
    logic [B_DEPTH-1:0]    ent_vld;
    logic [B_DEPTH-1:0]    ent_vld_nxt;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [STV_W-1:0]      starve_cnt;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  sel_a;
    logic                  sel_b;
    logic                  grant;
    logic [GPR_ADDR_W-1:0] grant_addr;
    logic [XLEN-1:0]       grant_data;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign b_ready_o = !full;
    assign push      = b_valid_i && !full;

    // B wins when A is idle, when the FIFO is full, or when B has waited STARVE_MAX A grants.
    assign sel_b     = !empty && (!a_valid_i || full || (starve_cnt == STV_LIM));
    assign sel_a     = a_valid_i && !sel_b;
    assign a_ready_o = sel_a;
    assign grant     = sel_a || sel_b;

    assign grant_addr = sel_b ? ent_addr[rd_ptr] : a_addr_i;
    assign grant_data = sel_b ? ent_data[rd_ptr] : a_data_i;

    always_comb begin
        ent_vld_nxt = ent_vld;
        if (push) begin
            ent_vld_nxt[wr_ptr] = 1'b1;
        end
        if (sel_b) begin
            ent_vld_nxt[rd_ptr] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_addr[wr_ptr] <= b_addr_i;
            ent_data[wr_ptr] <= b_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_vld    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            ent_vld <= ent_vld_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (sel_b) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(sel_b);
            if (empty || sel_b) begin
                starve_cnt <= '0;
            end else if (sel_a && (starve_cnt != STV_LIM)) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

    // x0 results are consumed by the grant but never reach the register file.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            wr_en_o <= grant && (grant_addr != '0);
            if (grant && (grant_addr != '0)) begin
                wr_addr_o <= grant_addr;
                wr_data_o <= grant_data;
            end
        end
    end

    assign r1_fwd_o = wr_en_o && (r1_addr_i == wr_addr_o) && (r1_addr_i != '0);
    assign r2_fwd_o = wr_en_o && (r2_addr_i == wr_addr_o) && (r2_addr_i != '0);

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < B_DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] != '0) &&
                ((ent_addr[i] == r1_addr_i) || (ent_addr[i] == r2_addr_i))) begin
                hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_wb_arb.sv
// Directed bench for rv_wb_arb: grant policy, starvation limit, FIFO full, x0, hazard/forward, reset.
module tb_rv_wb_arb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        a_valid_i;
    logic        a_ready_o;
    logic [4:0]  a_addr_i;
    logic [31:0] a_data_i;
    logic        b_valid_i;
    logic        b_ready_o;
    logic [4:0]  b_addr_i;
    logic [31:0] b_data_i;
    logic        wr_en_o;
    logic [4:0]  wr_addr_o;
    logic [31:0] wr_data_o;
    logic [4:0]  r1_addr_i;
    logic [4:0]  r2_addr_i;
    logic        r1_fwd_o;
    logic        r2_fwd_o;
    logic        hazard_o;

    int checks   = 0;
    int failures = 0;

    rv_wb_arb #(.XLEN(32), .GPR_ADDR_W(5), .B_DEPTH(2), .STARVE_MAX(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .r1_addr_i(r1_addr_i), .r2_addr_i(r2_addr_i),
        .r1_fwd_o(r1_fwd_o), .r2_fwd_o(r2_fwd_o), .hazard_o(hazard_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_inputs();
        a_valid_i = 1'b0; a_addr_i = '0; a_data_i = '0;
        b_valid_i = 1'b0; b_addr_i = '0; b_data_i = '0;
        r1_addr_i = '0;   r2_addr_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        tick(); tick();
        #1;
        checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en_o); end
        checks++; if (wr_addr_o !== 5'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr_o); end
        checks++; if (wr_data_o !== 32'd0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", wr_data_o); end
        checks++; if (b_ready_o !== 1'b1) begin failures++; $display("FAIL reset_b_ready got=%b exp=1", b_ready_o); end
        checks++; if ({a_ready_o, hazard_o, r1_fwd_o, r2_fwd_o} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {a_ready_o, hazard_o, r1_fwd_o, r2_fwd_o}); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_a_stream();
        for (int i = 0; i < 5; i++) begin
            a_valid_i = 1'b1; a_addr_i = 5'(i + 1); a_data_i = 32'h10 + 32'(i);
            r1_addr_i = 5'(i);
            #1;
            checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL a_stream_ready[%0d] got=%b exp=1", i, a_ready_o); end
            checks++; if (wr_en_o !== (i > 0)) begin failures++; $display("FAIL a_stream_wr_en[%0d] got=%b exp=%b", i, wr_en_o, (i > 0)); end
            checks++; if (r1_fwd_o !== (i > 0)) begin failures++; $display("FAIL a_stream_fwd[%0d] got=%b exp=%b", i, r1_fwd_o, (i > 0)); end
            if (i > 0) begin
                checks++; if (wr_addr_o !== 5'(i) || wr_data_o !== 32'h10 + 32'(i - 1)) begin
                    failures++; $display("FAIL a_stream_wr[%0d] got=%0d/%h exp=%0d/%h", i, wr_addr_o, wr_data_o, i, 32'h10 + 32'(i - 1)); end
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd5 || wr_data_o !== 32'h14) begin
            failures++; $display("FAIL a_stream_last got=%b/%0d/%h exp=1/5/14", wr_en_o, wr_addr_o, wr_data_o); end
        tick();
        #1;
        checks++; if (wr_en_o !== 1'b0 || wr_addr_o !== 5'd5) begin
            failures++; $display("FAIL a_stream_hold got=%b/%0d exp=0/5", wr_en_o, wr_addr_o); end
        tick();
    endtask

    task automatic test_b_single();
        b_valid_i = 1'b1; b_addr_i = 5'd7; b_data_i = 32'hDEAD; r1_addr_i = 5'd7;
        #1;
        checks++; if (b_ready_o !== 1'b1 || hazard_o !== 1'b0) begin
            failures++; $display("FAIL b_push_cycle got=rdy%b/hz%b exp=rdy1/hz0", b_ready_o, hazard_o); end
        tick();
        b_valid_i = 1'b0;
        #1;
        checks++; if (wr_en_o !== 1'b0 || hazard_o !== 1'b1) begin
            failures++; $display("FAIL b_grant_cycle got=wr%b/hz%b exp=wr0/hz1", wr_en_o, hazard_o); end
        tick();
        #1;
        checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd7 || wr_data_o !== 32'hDEAD) begin
            failures++; $display("FAIL b_write got=%b/%0d/%h exp=1/7/dead", wr_en_o, wr_addr_o, wr_data_o); end
        checks++; if (hazard_o !== 1'b0 || r1_fwd_o !== 1'b1) begin
            failures++; $display("FAIL b_write_fwd got=hz%b/fwd%b exp=hz0/fwd1", hazard_o, r1_fwd_o); end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_starve();
        a_valid_i = 1'b1; a_addr_i = 5'd10; a_data_i = 32'hA0;
        b_valid_i = 1'b1; b_addr_i = 5'd3;  b_data_i = 32'hB3;
        tick();
        b_valid_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL starve_a_win[%0d] got=%b exp=1", c, a_ready_o); end
            tick();
        end
        #1;
        checks++; if (a_ready_o !== 1'b0) begin failures++; $display("FAIL starve_b_forced got=%b exp=0", a_ready_o); end
        tick();
        b_valid_i = 1'b1; b_addr_i = 5'd4; b_data_i = 32'hB4;
        #1;
        checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd3 || wr_data_o !== 32'hB3) begin
            failures++; $display("FAIL starve_b_write got=%b/%0d/%h exp=1/3/b3", wr_en_o, wr_addr_o, wr_data_o); end
        tick();
        b_valid_i = 1'b0;
        #1;
        checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL starve_cnt_cleared got=%b exp=1", a_ready_o); end
        tick();
        a_valid_i = 1'b0;
        #1;
        checks++; if (wr_addr_o !== 5'd10 || wr_data_o !== 32'hA0) begin
            failures++; $display("FAIL starve_a_write got=%0d/%h exp=10/a0", wr_addr_o, wr_data_o); end
        tick();
        #1;
        checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd4 || wr_data_o !== 32'hB4) begin
            failures++; $display("FAIL starve_drain got=%b/%0d/%h exp=1/4/b4", wr_en_o, wr_addr_o, wr_data_o); end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_full();
        a_valid_i = 1'b1; a_addr_i = 5'd11; a_data_i = 32'hA1;
        b_valid_i = 1'b1; b_addr_i = 5'd20; b_data_i = 32'hC0;
        tick();
        b_addr_i = 5'd21; b_data_i = 32'hC1;
        #1;
        checks++; if (b_ready_o !== 1'b1 || a_ready_o !== 1'b1) begin
            failures++; $display("FAIL full_second_push got=rdy%b/a%b exp=rdy1/a1", b_ready_o, a_ready_o); end
        tick();
        b_addr_i = 5'd22; b_data_i = 32'hC2;
        #1;
        checks++; if (b_ready_o !== 1'b0 || a_ready_o !== 1'b0) begin
            failures++; $display("FAIL full_blocked got=rdy%b/a%b exp=rdy0/a0", b_ready_o, a_ready_o); end
        tick();
        #1;
        checks++; if (b_ready_o !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", b_ready_o); end
        checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd20 || wr_data_o !== 32'hC0) begin
            failures++; $display("FAIL full_b_write got=%b/%0d/%h exp=1/20/c0", wr_en_o, wr_addr_o, wr_data_o); end
        tick();
        idle_inputs();
        #1;
        checks++; if (wr_addr_o !== 5'd11 || b_ready_o !== 1'b0) begin
            failures++; $display("FAIL full_refill got=%0d/rdy%b exp=11/rdy0", wr_addr_o, b_ready_o); end
        tick();
        #1;
        checks++; if (wr_addr_o !== 5'd21 || wr_data_o !== 32'hC1) begin
            failures++; $display("FAIL full_order1 got=%0d/%h exp=21/c1", wr_addr_o, wr_data_o); end
        tick();
        #1;
        checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd22 || wr_data_o !== 32'hC2) begin
            failures++; $display("FAIL full_order2 got=%b/%0d/%h exp=1/22/c2", wr_en_o, wr_addr_o, wr_data_o); end
        tick();
    endtask

    task automatic test_x0();
        a_valid_i = 1'b1; a_addr_i = 5'd0; a_data_i = 32'h55;
        #1;
        checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL x0_a_ready got=%b exp=1", a_ready_o); end
        tick();
        a_valid_i = 1'b0;
        b_valid_i = 1'b1; b_addr_i = 5'd0; b_data_i = 32'h66;
        #1;
        checks++; if (wr_en_o !== 1'b0 || wr_addr_o !== 5'd22 || wr_data_o !== 32'hC2) begin
            failures++; $display("FAIL x0_a_no_write got=%b/%0d/%h exp=0/22/c2", wr_en_o, wr_addr_o, wr_data_o); end
        tick();
        b_valid_i = 1'b0;
        #1;
        checks++; if (hazard_o !== 1'b0 || r1_fwd_o !== 1'b0) begin
            failures++; $display("FAIL x0_hazard_fwd got=hz%b/fwd%b exp=0/0", hazard_o, r1_fwd_o); end
        tick();
        #1;
        checks++; if (wr_en_o !== 1'b0 || b_ready_o !== 1'b1) begin
            failures++; $display("FAIL x0_b_consumed got=wr%b/rdy%b exp=wr0/rdy1", wr_en_o, b_ready_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard_reset();
        a_valid_i = 1'b1; a_addr_i = 5'd12; a_data_i = 32'hA2;
        b_valid_i = 1'b1; b_addr_i = 5'd9;  b_data_i = 32'h99;
        r2_addr_i = 5'd9;
        #1;
        checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL hz_push_cycle got=%b exp=0", hazard_o); end
        tick();
        b_valid_i = 1'b0;
        #1;
        checks++; if (hazard_o !== 1'b1 || a_ready_o !== 1'b1) begin
            failures++; $display("FAIL hz_buffered got=hz%b/a%b exp=hz1/a1", hazard_o, a_ready_o); end
        tick();
        a_valid_i = 1'b0;
        #1;
        checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL hz_grant_cycle got=%b exp=1", hazard_o); end
        tick();
        a_valid_i = 1'b1; a_addr_i = 5'd13; a_data_i = 32'hA3;
        b_valid_i = 1'b1; b_addr_i = 5'd14; b_data_i = 32'hB5;
        #1;
        checks++; if (hazard_o !== 1'b0 || r2_fwd_o !== 1'b1 || wr_addr_o !== 5'd9 || wr_data_o !== 32'h99) begin
            failures++; $display("FAIL hz_write_cycle got=hz%b/fwd%b/%0d/%h exp=hz0/fwd1/9/99", hazard_o, r2_fwd_o, wr_addr_o, wr_data_o); end
        tick();
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        r1_addr_i = 5'd13; r2_addr_i = 5'd14;
        #1;
        checks++; if (hazard_o !== 1'b1 || r1_fwd_o !== 1'b1) begin
            failures++; $display("FAIL pre_reset got=hz%b/fwd%b exp=hz1/fwd1", hazard_o, r1_fwd_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if ({wr_en_o, hazard_o, r1_fwd_o, r2_fwd_o, a_ready_o} !== 5'b00000 ||
                      wr_addr_o !== 5'd0 || wr_data_o !== 32'd0 || b_ready_o !== 1'b1) begin
            failures++; $display("FAIL mid_reset got=wr%b/%0d/%h hz%b fwd%b%b rdy%b exp=wr0/0/0 hz0 fwd00 rdy1",
                                 wr_en_o, wr_addr_o, wr_data_o, hazard_o, r1_fwd_o, r2_fwd_o, b_ready_o); end
        tick();
        #1;
        checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL post_reset_no_write got=%b exp=0", wr_en_o); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_a_stream();
        test_b_single();
        test_starve();
        test_full();
        test_x0();
        test_hazard_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
